// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage: the canonical NOP,
// fetch exception cause codes, the default address width and fetch states.
package cpu_pkg;

    localparam int XLEN_DEFAULT = 64;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] EXC_INSTR_ACCESS     = 4'd1;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ifetch_stage_if.sv
// Bundle of the instruction-memory bus and the IF/ID output slot handshake.
// master = the fetch stage, slave = memory plus decode.
interface ifetch_stage_if #(
    parameter int XLEN = cpu_pkg::XLEN_DEFAULT
);
    // Instruction memory side
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_instr;
    logic            imem_exc_en;
    logic [3:0]      imem_exc_code;
    logic [XLEN-1:0] imem_exc_val;

    // IF/ID slot toward decode
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            out_exc_en;
    logic [3:0]      out_exc_code;
    logic [XLEN-1:0] out_exc_val;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  imem_exc_en,
        input  imem_exc_code,
        input  imem_exc_val,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output out_exc_en,
        output out_exc_code,
        output out_exc_val
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output imem_exc_en,
        output imem_exc_code,
        output imem_exc_val,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  out_exc_en,
        input  out_exc_code,
        input  out_exc_val
    );

endinterface

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the combinational
// instruction memory and registers the fetched entry (or fetch fault) into
// the IF/ID slot. After issuing a faulting entry it stops fetching until a
// redirect arrives.
module ifetch_stage
    import cpu_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    ifetch_stage_if.master  bus
);

    // Sequential PC increment; wraps modulo 2^XLEN by plain truncation.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

    // Instructions are 4-byte aligned; any low bit set is a misaligned fetch.
    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        return |pc[1:0];
    endfunction

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;

    logic            vld_p1;
    logic [XLEN-1:0] pc_p1;
    logic [31:0]     instr_p1;
    logic            exc_en_p1;
    logic [3:0]      exc_code_p1;
    logic [XLEN-1:0] exc_val_p1;

    logic            advance;

    // The slot can take a new entry when empty or being drained this cycle.
    assign advance = !vld_p1 || bus.out_ready;

    // ---- fetch / IF-ID slot boundary ----
    // PC, fetch state and slot update; reset beats redirect beats fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            state_q     <= FETCH_RUN;
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            instr_p1    <= NOP_INSTR;
            exc_en_p1   <= 1'b0;
            exc_code_p1 <= '0;
            exc_val_p1  <= '0;
        end else if (redirect_en) begin
            // The current slot entry is dropped even if decode is accepting it.
            pc_q        <= redirect_pc;
            state_q     <= FETCH_RUN;
            vld_p1      <= 1'b0;
            instr_p1    <= NOP_INSTR;
            exc_en_p1   <= 1'b0;
            exc_code_p1 <= '0;
            exc_val_p1  <= '0;
        end else if (advance) begin
            if (state_q == FETCH_HOLD) begin
                // Fault already issued: drain the slot and stay parked.
                vld_p1      <= 1'b0;
                instr_p1    <= NOP_INSTR;
                exc_en_p1   <= 1'b0;
                exc_code_p1 <= '0;
                exc_val_p1  <= '0;
            end else if (pc_misaligned(pc_q)) begin
                // Memory response is meaningless for a misaligned address.
                vld_p1      <= 1'b1;
                pc_p1       <= pc_q;
                instr_p1    <= NOP_INSTR;
                exc_en_p1   <= 1'b1;
                exc_code_p1 <= EXC_INSTR_MISALIGNED;
                exc_val_p1  <= pc_q;
                state_q     <= FETCH_HOLD;
            end else if (bus.imem_exc_en) begin
                vld_p1      <= 1'b1;
                pc_p1       <= pc_q;
                instr_p1    <= NOP_INSTR;
                exc_en_p1   <= 1'b1;
                exc_code_p1 <= bus.imem_exc_code;
                exc_val_p1  <= bus.imem_exc_val;
                state_q     <= FETCH_HOLD;
            end else begin
                vld_p1      <= 1'b1;
                pc_p1       <= pc_q;
                instr_p1    <= bus.imem_instr;
                exc_en_p1   <= 1'b0;
                exc_code_p1 <= '0;
                exc_val_p1  <= '0;
                pc_q        <= pc_plus4(pc_q);
            end
        end
    end

    assign bus.imem_addr    = pc_q;
    assign bus.out_valid    = vld_p1;
    assign bus.out_pc       = pc_p1;
    assign bus.out_instr    = instr_p1;
    assign bus.out_exc_en   = exc_en_p1;
    assign bus.out_exc_code = exc_code_p1;
    assign bus.out_exc_val  = exc_val_p1;

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: a directed vector table covering reset, stalls,
// redirects, faults, misalignment and PC wrap, followed by a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_ifetch_stage;
    import cpu_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_en = 1'b0;
    logic [63:0] redirect_pc = '0;

    logic        rand_mode = 1'b0;
    logic        tbl_exc_en = 1'b0;
    logic [3:0]  tbl_exc_code = '0;
    logic [63:0] tbl_exc_val = '0;

    int n_pass = 0;
    int n_total = 0;

    ifetch_stage_if #(.XLEN(64)) bus ();

    ifetch_stage #(.XLEN(64), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Contents of the instruction memory, as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'h0050_0093;
        if (a == 64'h4) return 32'h0010_0113;
        return a[31:0] ^ 32'h5A5A_0003;
    endfunction

    // Addresses that raise an access fault during the randomized run.
    function automatic bit fault_at(input logic [63:0] a);
        return a[8:4] == 5'h1B;
    endfunction

    // Memory model: combinational response to the presented address.
    always_comb begin
        bus.imem_instr    = mem_word(bus.imem_addr);
        bus.imem_exc_en   = tbl_exc_en;
        bus.imem_exc_code = tbl_exc_code;
        bus.imem_exc_val  = tbl_exc_val;
        if (rand_mode && fault_at(bus.imem_addr)) begin
            bus.imem_exc_en   = 1'b1;
            bus.imem_exc_code = 4'd1;
            bus.imem_exc_val  = bus.imem_addr;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        bit          rst;
        bit          redir;
        logic [63:0] rpc;
        bit          rdy;
        bit          xe;
        logic [3:0]  xc;
        logic [63:0] xv;
        bit          ev;
        bit          cpc;
        logic [63:0] epc;
        logic [31:0] ei;
        bit          ee;
        logic [3:0]  ec;
        logic [63:0] eval;
        logic [63:0] eaddr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit rd, input logic [63:0] rpc, input bit rdy,
                       input bit xe, input logic [3:0] xc, input logic [63:0] xv,
                       input bit ev, input bit cpc, input logic [63:0] epc, input logic [31:0] ei,
                       input bit ee, input logic [3:0] ec, input logic [63:0] eval,
                       input logic [63:0] eaddr);
        vec_t v;
        v.rst = r; v.redir = rd; v.rpc = rpc; v.rdy = rdy;
        v.xe = xe; v.xc = xc; v.xv = xv;
        v.ev = ev; v.cpc = cpc; v.epc = epc; v.ei = ei;
        v.ee = ee; v.ec = ec; v.eval = eval; v.eaddr = eaddr;
        vecs.push_back(v);
    endtask

    task automatic fill_table();
        localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;
        // rst red rpc       rdy xe xc  xv       ev cpc epc       instr               ee ec val      addr
        add(1, 0, 0,         0,  0, 0, 0,        0, 1, 0,        NOP,                0, 0, 0,       64'h0);
        add(1, 0, 0,         1,  0, 0, 0,        0, 1, 0,        NOP,                0, 0, 0,       64'h0);
        add(0, 0, 0,         1,  0, 0, 0,        1, 1, 64'h0,    32'h0050_0093,      0, 0, 0,       64'h4);
        add(0, 0, 0,         1,  0, 0, 0,        1, 1, 64'h4,    32'h0010_0113,      0, 0, 0,       64'h8);
        add(0, 0, 0,         1,  0, 0, 0,        1, 1, 64'h8,    mem_word(64'h8),    0, 0, 0,       64'hC);
        add(0, 0, 0,         0,  0, 0, 0,        1, 1, 64'h8,    mem_word(64'h8),    0, 0, 0,       64'hC);
        add(0, 0, 0,         0,  0, 0, 0,        1, 1, 64'h8,    mem_word(64'h8),    0, 0, 0,       64'hC);
        add(0, 0, 0,         0,  0, 0, 0,        1, 1, 64'h8,    mem_word(64'h8),    0, 0, 0,       64'hC);
        add(0, 0, 0,         1,  0, 0, 0,        1, 1, 64'hC,    mem_word(64'hC),    0, 0, 0,       64'h10);
        add(0, 1, 64'h100,   0,  0, 0, 0,        0, 0, 0,        NOP,                0, 0, 0,       64'h100);
        add(0, 0, 0,         1,  0, 0, 0,        1, 1, 64'h100,  mem_word(64'h100),  0, 0, 0,       64'h104);
        add(0, 1, 64'h2000,  1,  0, 0, 0,        0, 0, 0,        NOP,                0, 0, 0,       64'h2000);
        add(0, 0, 0,         1,  1, 1, 64'h2000, 1, 1, 64'h2000, NOP,                1, 1, 64'h2000, 64'h2000);
        add(0, 0, 0,         1,  0, 0, 0,        0, 0, 0,        NOP,                0, 0, 0,       64'h2000);
        add(0, 0, 0,         1,  0, 0, 0,        0, 0, 0,        NOP,                0, 0, 0,       64'h2000);
        add(0, 1, 64'h80,    1,  0, 0, 0,        0, 0, 0,        NOP,                0, 0, 0,       64'h80);
        add(0, 0, 0,         1,  0, 0, 0,        1, 1, 64'h80,   mem_word(64'h80),   0, 0, 0,       64'h84);
        add(0, 1, 64'h102,   1,  0, 0, 0,        0, 0, 0,        NOP,                0, 0, 0,       64'h102);
        add(0, 0, 0,         1,  0, 0, 0,        1, 1, 64'h102,  NOP,                1, 0, 64'h102, 64'h102);
        add(0, 0, 0,         1,  0, 0, 0,        0, 0, 0,        NOP,                0, 0, 0,       64'h102);
        add(0, 1, TOP,       1,  0, 0, 0,        0, 0, 0,        NOP,                0, 0, 0,       TOP);
        add(0, 0, 0,         1,  0, 0, 0,        1, 1, TOP,      mem_word(TOP),      0, 0, 0,       64'h0);
        add(0, 0, 0,         1,  0, 0, 0,        1, 1, 64'h0,    32'h0050_0093,      0, 0, 0,       64'h4);
        add(0, 0, 0,         0,  0, 0, 0,        1, 1, 64'h0,    32'h0050_0093,      0, 0, 0,       64'h4);
        add(1, 0, 0,         0,  0, 0, 0,        0, 1, 0,        NOP,                0, 0, 0,       64'h0);
        add(0, 0, 0,         1,  0, 0, 0,        1, 1, 64'h0,    32'h0050_0093,      0, 0, 0,       64'h4);
        add(0, 1, 64'h40,    1,  0, 0, 0,        0, 0, 0,        NOP,                0, 0, 0,       64'h40);
        add(0, 1, 64'h44,    1,  0, 0, 0,        0, 0, 0,        NOP,                0, 0, 0,       64'h44);
        add(0, 0, 0,         1,  0, 0, 0,        1, 1, 64'h44,   mem_word(64'h44),   0, 0, 0,       64'h48);
    endtask

    // Reference model: the next expected slot entry and fetch pointer,
    // derived from the architectural rules of the fetch stream.
    typedef struct {
        bit          v;
        logic [63:0] pc;
        logic [31:0] ins;
        bit          e;
        logic [3:0]  c;
        logic [63:0] val;
    } slot_t;

    slot_t       m_slot;
    logic [63:0] m_pc;
    bit          m_parked;

    task automatic clear_slot();
        m_slot.v = 0; m_slot.ins = NOP; m_slot.e = 0; m_slot.c = 0; m_slot.val = 0;
    endtask

    task automatic model_step(input bit r, input bit rd, input logic [63:0] rpc, input bit rdy);
        if (r) begin
            m_pc = 64'h0; m_parked = 0; clear_slot(); m_slot.pc = 0;
        end else if (rd) begin
            m_pc = rpc; m_parked = 0; clear_slot();
        end else if (!m_slot.v || rdy) begin
            if (m_parked) begin
                clear_slot();
            end else if (m_pc % 4 != 0) begin
                m_slot = '{1, m_pc, NOP, 1, 4'd0, m_pc};
                m_parked = 1;
            end else if (fault_at(m_pc)) begin
                m_slot = '{1, m_pc, NOP, 1, 4'd1, m_pc};
                m_parked = 1;
            end else begin
                m_slot = '{1, m_pc, mem_word(m_pc), 0, 4'd0, 64'h0};
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    initial begin
        fill_table();

        // Directed vectors: drive on the falling edge, check just after the rising edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            redirect_en   = vecs[i].redir;
            redirect_pc   = vecs[i].rpc;
            bus.out_ready = vecs[i].rdy;
            tbl_exc_en    = vecs[i].xe;
            tbl_exc_code  = vecs[i].xc;
            tbl_exc_val   = vecs[i].xv;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].ev));
            if (vecs[i].cpc)
                check($sformatf("v%0d_pc", i), bus.out_pc, vecs[i].epc);
            check($sformatf("v%0d_instr", i), 64'(bus.out_instr), 64'(vecs[i].ei));
            check($sformatf("v%0d_exc_en", i), 64'(bus.out_exc_en), 64'(vecs[i].ee));
            check($sformatf("v%0d_exc_code", i), 64'(bus.out_exc_code), 64'(vecs[i].ec));
            check($sformatf("v%0d_exc_val", i), bus.out_exc_val, vecs[i].eval);
            check($sformatf("v%0d_imem_addr", i), bus.imem_addr, vecs[i].eaddr);
        end

        // Randomized run against the reference model, starting from reset.
        @(negedge clk);
        tbl_exc_en = 0; tbl_exc_code = 0; tbl_exc_val = 0;
        rand_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            bit          r, rd, rdy;
            logic [63:0] rpc;
            if (i != 0) @(negedge clk);
            r   = (i == 0) || ($urandom_range(0, 79) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0)
                rpc = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
            else
                rpc = 64'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            rst = r; redirect_en = rd; redirect_pc = rpc; bus.out_ready = rdy;
            model_step(r, rd, rpc, rdy);
            @(posedge clk);
            #1;
            check($sformatf("r%0d_valid", i), 64'(bus.out_valid), 64'(m_slot.v));
            if (m_slot.v)
                check($sformatf("r%0d_pc", i), bus.out_pc, m_slot.pc);
            check($sformatf("r%0d_instr", i), 64'(bus.out_instr), 64'(m_slot.ins));
            check($sformatf("r%0d_exc_en", i), 64'(bus.out_exc_en), 64'(m_slot.e));
            check($sformatf("r%0d_exc_code", i), 64'(bus.out_exc_code), 64'(m_slot.c));
            check($sformatf("r%0d_exc_val", i), bus.out_exc_val, m_slot.val);
            check($sformatf("r%0d_imem_addr", i), bus.imem_addr, m_pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction fetch stage sitting directly upstream of the combinational instruction memory.
- Owns the program counter and drives the memory address. Captures the returned instruction and any fetch exception into a registered IF/ID output slot, using a valid/ready handshake toward decode.
- Accepts redirects from branch/jump/trap logic.
- Stops fetching after a faulting fetch until it is redirected.

Parameters:
- XLEN, 64, address/PC width.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_en  in  1  load new PC and flush the output slot (branch taken, jump, trap, mret).
- redirect_pc  in  XLEN  redirect target.
- imem_addr  out  XLEN  fetch address to instruction memory (combinational from PC register).
- imem_instr  in  32  instruction word returned in the same cycle.
- imem_exc_en  in  1  memory reports an access fault for imem_addr.
- imem_exc_code  in  4  memory exception cause.
- imem_exc_val  in  XLEN  memory exception value (faulting PC).
- out_valid  out  1  output slot holds a fetched entry.
- out_ready  in  1  decode accepts the entry this cycle.
- out_pc  out  XLEN  PC of the entry.
- out_instr  out  32  instruction; NOP (32'h00000013) when invalid or faulting.
- out_exc_en  out  1  entry carries a fetch exception.
- out_exc_code  out  4  cause (0 = instruction address misaligned, 1 = instruction access fault).
- out_exc_val  out  XLEN  mtval candidate (faulting PC).

Behaviour:
- Reset (rst=1 at edge):
  - pc_q = RESET_PC; state = RUN.
  - out_valid = 0; out_pc = 0; out_instr = 32'h00000013.
  - out_exc_en = 0; out_exc_code = 0; out_exc_val = 0.
  - Reset mid-fetch discards the slot and any HOLD state.
- imem_addr = pc_q, always, combinationally.
- advance = !out_valid || out_ready.
- States: RUN (fetching), HOLD (a faulting entry was issued; no further fetches).
- Priority at each edge is rst > redirect_en > normal operation.
- redirect_en=1:
  - pc_q = redirect_pc; state = RUN.
  - out_valid = 0; out_instr = NOP; out_exc_* = 0.
  - Overrides out_ready, stall and HOLD in the same cycle.
  - The entry currently in the slot is dropped, even if out_ready=1. Decode must not treat it as consumed.
- RUN with advance=1 and pc_q[1:0] != 0 (misaligned):
  - Slot = {pc_q, NOP, exc_en=1, code=0, val=pc_q}; out_valid = 1; state = HOLD.
  - pc_q unchanged; imem outputs are ignored.
- RUN with advance=1 and imem_exc_en=1:
  - Slot = {pc_q, NOP, exc_en=1, code=imem_exc_code, val=imem_exc_val}; out_valid = 1; state = HOLD; pc_q unchanged.
- RUN with advance=1, otherwise:
  - Slot = {pc_q, imem_instr, exc_en=0, code=0, val=0}; out_valid = 1.
  - pc_q = pc_q + 4, modulo 2^XLEN (0xFFFF_FFFF_FFFF_FFFC wraps to 0).
- advance=0 (out_valid=1, out_ready=0): slot and pc_q hold; out_* stable.
- HOLD with advance=1: out_valid = 0; out_instr = NOP; out_exc_* = 0; remain in HOLD until redirect_en or rst.
- Latency and throughput:
  - One cycle from pc_q to out_*.
  - Throughput one instruction per cycle when out_ready=1.
  - Back-to-back redirects each take effect on their own edge.
- Only registered values are presented on out_*; no combinational path from imem_* to out_*.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INSTR = 32'h00000013.
  - EXC_INSTR_MISALIGNED = 4'd0; EXC_INSTR_ACCESS = 4'd1.
  - XLEN default.
  - Fetch state enum {RUN, HOLD}.
- No sub-module. PC update and slot register stay in one module (about 150 lines).

Test Plan:
- Reset, then release with imem returning 0x00500093 at 0x0 and 0x00100113 at 0x4, out_ready=1 -> out_valid rises one cycle after reset. Output is pc 0x0 / 0x00500093, then pc 0x4 / 0x00100113; imem_addr steps 0, 4, 8.
- Stall: out_ready=0 for 3 cycles while the slot holds pc 0x8 -> out_pc stays 0x8, pc_q stays 0xC, and no entry is skipped or duplicated once out_ready=1.
- Redirect with stall: out_ready=0, redirect_en=1, redirect_pc=0x100 -> next cycle out_valid=0 and imem_addr=0x100. The following cycle outputs pc 0x100.
- Access fault: imem_exc_en=1, code 1, val 0x2000 at pc 0x2000 -> one entry with exc_en=1, code 1, val 0x2000, instr 0x13. Then out_valid=0 and imem_addr stays 0x2000 until a redirect to 0x80 resumes fetching at 0x80.
- Misaligned redirect to 0x102 -> entry with exc_en=1, code 0, val 0x102; state HOLD.
- PC wrap: redirect to 0xFFFF_FFFF_FFFF_FFFC -> that entry is issued, then imem_addr=0x0. Asserting rst mid-stall clears out_valid and sets pc to RESET_PC.
